// File: rtl/otfs_demodulator_if.sv
// FFT-side AXI-Stream bundle of the OTFS demodulator: config, FFT input and FFT output channels.
// The demodulator takes the master modport; the FFT core (or its model) takes the slave modport.
interface otfs_demodulator_if;
    logic [7:0]  CfgTdata;
    logic        CfgTvalid;
    logic        CfgTready;
    logic [31:0] FftInTdata;
    logic        FftInTvalid;
    logic        FftInTready;
    logic        FftInTlast;
    logic [47:0] FftOutTdata;
    logic        FftOutTvalid;
    logic        FftOutTready;

    modport master (
        output CfgTdata, CfgTvalid, FftInTdata, FftInTvalid, FftInTlast, FftOutTready,
        input  CfgTready, FftInTready, FftOutTdata, FftOutTvalid
    );

    modport slave (
        input  CfgTdata, CfgTvalid, FftInTdata, FftInTvalid, FftInTlast, FftOutTready,
        output CfgTready, FftInTready, FftOutTdata, FftOutTvalid
    );
endinterface

// File: rtl/otfs_demodulator.sv
// OTFS receive path: captures one frame through a corner-turn buffer, streams it to an
// external FFT in 2^LOG2N-sample blocks and hard-demaps the FFT output to 4QAM codes.
module otfs_demodulator #(
    parameter int unsigned LOG2N   = 6,
    parameter logic [7:0]  FFT_CFG = 8'h01
) (
    input  logic                  Clk,
    input  logic                  Srst,
    input  logic                  Start,
    input  logic                  RxDataValid,
    input  logic [15:0]           RxDataRe,
    input  logic [15:0]           RxDataIm,
    otfs_demodulator_if.master    fft,
    output logic                  SymValid,
    output logic [1:0]            SymData,
    output logic                  SymLast,
    output logic                  Busy,
    output logic                  FrameDone,
    output logic                  RxOverrun
);
    localparam int unsigned AW    = 2 * LOG2N;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {IDLE, CONFIG, CAPTURE, FEED, DRAIN} state_t;
    state_t state;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   mem_q;
    logic [AW-1:0] wr_cnt, rd_addr, beat_cnt, sym_cnt;
    logic          rd_done, rd_pend, rd_pend_last;
    logic          skid_valid, skid_last;
    logic [31:0]   skid_data;
    logic [1:0]    occ;
    logic          pop, rd_issue, start_ok;
    logic          unused_fft_bits;

    assign fft.FftOutTready = 1'b1;
    assign unused_fft_bits  = ^{fft.FftOutTdata[46:24], fft.FftOutTdata[22:0]};

    assign pop      = fft.FftInTvalid && fft.FftInTready;
    assign start_ok = (state == IDLE) && Start && !FrameDone;
    // Output register, skid register and the read in flight together hold at most two
    // beats, so a read is issued only when a slot is guaranteed once it lands.
    assign occ      = 2'(fft.FftInTvalid) + 2'(skid_valid) + 2'(rd_pend);
    assign rd_issue = (state == FEED) && !rd_done && ((occ - 2'(pop)) < 2'd2);

    always_ff @(posedge Clk) begin
        if (state == CAPTURE && RxDataValid)
            mem[{wr_cnt[LOG2N-1:0], wr_cnt[AW-1:LOG2N]}] <= {RxDataIm, RxDataRe};
        if (rd_issue)
            mem_q <= mem[rd_addr];
    end

    always_ff @(posedge Clk) begin
        if (Srst) begin
            state           <= IDLE;
            fft.CfgTvalid   <= 1'b0;
            fft.CfgTdata    <= '0;
            fft.FftInTvalid <= 1'b0;
            fft.FftInTlast  <= 1'b0;
            fft.FftInTdata  <= '0;
            SymValid        <= 1'b0;
            SymData         <= '0;
            SymLast         <= 1'b0;
            Busy            <= 1'b0;
            FrameDone       <= 1'b0;
            RxOverrun       <= 1'b0;
            wr_cnt          <= '0;
            rd_addr         <= '0;
            beat_cnt        <= '0;
            sym_cnt         <= '0;
            rd_done         <= 1'b0;
            rd_pend         <= 1'b0;
            rd_pend_last    <= 1'b0;
            skid_valid      <= 1'b0;
            skid_last       <= 1'b0;
            skid_data       <= '0;
        end else begin
            FrameDone <= 1'b0;

            if (start_ok)
                RxOverrun <= 1'b0;
            else if (RxDataValid && Busy && state != CAPTURE)
                RxOverrun <= 1'b1;

            case (state)
                IDLE: if (start_ok) begin
                    state         <= CONFIG;
                    Busy          <= 1'b1;
                    fft.CfgTvalid <= 1'b1;
                    fft.CfgTdata  <= FFT_CFG;
                    wr_cnt        <= '0;
                    rd_addr       <= '0;
                    rd_done       <= 1'b0;
                    beat_cnt      <= '0;
                    sym_cnt       <= '0;
                end
                CONFIG: if (fft.CfgTready) begin
                    fft.CfgTvalid <= 1'b0;
                    fft.CfgTdata  <= '0;
                    state         <= CAPTURE;
                end
                CAPTURE: if (RxDataValid) begin
                    wr_cnt <= wr_cnt + 1'b1;
                    if (&wr_cnt)
                        state <= FEED;
                end
                FEED: if (pop && &beat_cnt)
                    state <= DRAIN;
                DRAIN: if (SymLast) begin
                    state     <= IDLE;
                    Busy      <= 1'b0;
                    FrameDone <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_pend_last <= &rd_addr[LOG2N-1:0];
                rd_addr      <= rd_addr + 1'b1;
                if (&rd_addr)
                    rd_done <= 1'b1;
            end
            if (pop)
                beat_cnt <= beat_cnt + 1'b1;

            // The output register only moves when empty or accepted; skid drains first.
            if (pop || !fft.FftInTvalid) begin
                if (skid_valid) begin
                    fft.FftInTvalid <= 1'b1;
                    fft.FftInTdata  <= skid_data;
                    fft.FftInTlast  <= skid_last;
                    skid_valid      <= rd_pend;
                    skid_data       <= mem_q;
                    skid_last       <= rd_pend_last;
                end else if (rd_pend) begin
                    fft.FftInTvalid <= 1'b1;
                    fft.FftInTdata  <= mem_q;
                    fft.FftInTlast  <= rd_pend_last;
                end else begin
                    fft.FftInTvalid <= 1'b0;
                    fft.FftInTlast  <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_data  <= mem_q;
                skid_last  <= rd_pend_last;
            end

            if ((state == FEED || state == DRAIN) && fft.FftOutTvalid) begin
                SymValid <= 1'b1;
                SymData  <= {~fft.FftOutTdata[23], fft.FftOutTdata[47]};
                SymLast  <= &sym_cnt;
                sym_cnt  <= sym_cnt + 1'b1;
            end else begin
                SymValid <= 1'b0;
                SymLast  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_otfs_demodulator.sv
// Scoreboard bench for otfs_demodulator with a sign-extending pass-through FFT model.
module tb_otfs_demodulator;
    logic        Clk = 1'b0;
    logic        Srst = 1'b1;
    logic        Start = 1'b0;
    logic        RxDataValid = 1'b0;
    logic [15:0] RxDataRe = '0;
    logic [15:0] RxDataIm = '0;
    logic        SymValid, SymLast, Busy, FrameDone, RxOverrun;
    logic [1:0]  SymData;
    logic        cfg_ready = 1'b0, bp_en = 1'b0, junk_valid = 1'b0;
    logic        rand_ready;
    logic        v1, v2;
    logic [47:0] d1, d2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_beat [4096];
    logic [1:0]  exp_sym  [4096];
    logic [32:0] beat_q [$];
    logic [1:0]  sym_q  [$];

    otfs_demodulator_if fft_if();

    otfs_demodulator #(.LOG2N(6), .FFT_CFG(8'h01)) dut (
        .Clk(Clk), .Srst(Srst), .Start(Start), .RxDataValid(RxDataValid),
        .RxDataRe(RxDataRe), .RxDataIm(RxDataIm), .fft(fft_if),
        .SymValid(SymValid), .SymData(SymData), .SymLast(SymLast),
        .Busy(Busy), .FrameDone(FrameDone), .RxOverrun(RxOverrun)
    );

    always #5 Clk = ~Clk;

    assign fft_if.CfgTready    = cfg_ready;
    assign fft_if.FftInTready  = bp_en ? rand_ready : 1'b1;
    assign fft_if.FftOutTvalid = v2 | junk_valid;
    assign fft_if.FftOutTdata  = d2;

    always @(posedge Clk) rand_ready <= 1'($urandom_range(0, 1));

    // Two-stage pass-through "FFT": each accepted beat comes back sign-extended to 24 bits.
    always @(posedge Clk) begin
        if (Srst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            d1 <= '0;
            d2 <= '0;
        end else begin
            v1 <= fft_if.FftInTvalid && fft_if.FftInTready;
            d1 <= {{8{fft_if.FftInTdata[31]}}, fft_if.FftInTdata[31:16],
                   {8{fft_if.FftInTdata[15]}}, fft_if.FftInTdata[15:0]};
            v2 <= v1;
            d2 <= d1;
        end
    end

    function automatic logic [50:0] out_vec();
        return {fft_if.CfgTvalid, fft_if.CfgTdata, fft_if.FftInTvalid, fft_if.FftInTlast,
                fft_if.FftInTdata, SymValid, SymData, SymLast, Busy, FrameDone, RxOverrun,
                fft_if.FftOutTready};
    endfunction

    task automatic pulse_start();
        @(posedge Clk); #1 Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
        n_checks++;
        if ({fft_if.CfgTvalid, Busy, RxOverrun} !== 3'b110) begin
            n_fail++;
            $display("FAIL start_response: got %b required 110 (CfgTvalid,Busy,RxOverrun)",
                     {fft_if.CfgTvalid, Busy, RxOverrun});
        end
    endtask

    // Holds CfgTready low for n cycles while pushing stray samples, then handshakes.
    task automatic cfg_handshake(input int n);
        for (int k = 0; k < n; k++) begin
            RxDataValid = 1'b1;
            RxDataRe    = 16'h7777;
            @(negedge Clk);
            n_checks++;
            if ({fft_if.CfgTvalid, fft_if.CfgTdata} !== 9'h101) begin
                n_fail++;
                $display("FAIL cfg_stall: got %h required 101", {fft_if.CfgTvalid, fft_if.CfgTdata});
            end
            @(posedge Clk); #1;
        end
        RxDataValid = 1'b0;
        cfg_ready   = 1'b1;
        @(posedge Clk);
    endtask

    // mode 0: Re=t Im=0; 1: demap boundary table; 2: random; 3: code = t mod 4
    task automatic capture_frame(input int mode);
        logic [11:0] tt, bi;
        logic [15:0] re, im;
        logic [1:0]  sym;
        for (int t = 0; t < 4096; t++) begin
            tt = 12'(t);
            bi = {tt[5:0], tt[11:6]};
            case (mode)
                0: begin re = 16'(t); im = 16'h0000; sym = 2'b10; end
                1: case (tt[1:0])
                       2'd0: begin re = 16'h0000; im = 16'h0000; sym = 2'b10; end
                       2'd1: begin re = 16'hFFFF; im = 16'h0001; sym = 2'b00; end
                       2'd2: begin re = 16'h0001; im = 16'hFFFF; sym = 2'b11; end
                       default: begin re = 16'hFFFF; im = 16'hFFFF; sym = 2'b01; end
                   endcase
                2: begin
                    re  = 16'($urandom);
                    im  = 16'($urandom);
                    sym = {($signed(re) >= 0), ($signed(im) < 0)};
                end
                default: begin
                    sym = tt[1:0];
                    re  = sym[1] ? 16'd1000 : -16'sd1000;
                    im  = sym[0] ? -16'sd1000 : 16'd1000;
                end
            endcase
            #1;
            cfg_ready   = 1'b0;
            RxDataValid = 1'b1;
            RxDataRe    = re;
            RxDataIm    = im;
            exp_beat[bi] = {(bi[5:0] == 6'd63), im, re};
            exp_sym[bi]  = sym;
            @(posedge Clk);
        end
        #1 RxDataValid = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            beat_q.push_back(exp_beat[i]);
            sym_q.push_back(exp_sym[i]);
        end
    endtask

    task automatic check_stream(input string name, input bit inject,
                                output int first_cyc, output int last_cyc);
        int          beats = 0, syms = 0, dones = 0, cyc = 0;
        bit          prev_stall = 1'b0, prev_symlast = 1'b0, injected = 1'b0;
        logic [32:0] prev_beat = '0, eb, got;
        logic [1:0]  es;
        first_cyc = -1;
        last_cyc  = -1;
        while (dones == 0 && cyc < 20000) begin
            @(negedge Clk);
            cyc++;
            RxDataValid = 1'b0;
            if (inject && !injected && fft_if.FftInTvalid) begin
                RxDataValid = 1'b1;
                injected    = 1'b1;
            end
            got = {fft_if.FftInTlast, fft_if.FftInTdata};
            if (prev_stall) begin
                n_checks++;
                if ({fft_if.FftInTvalid, got} !== {1'b1, prev_beat}) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got %h required %h", name,
                             {fft_if.FftInTvalid, got}, {1'b1, prev_beat});
                end
            end
            if (fft_if.FftInTvalid && fft_if.FftInTready) begin
                eb = (beat_q.size() > 0) ? beat_q.pop_front() : 33'h1_DEAD_BEEF;
                n_checks++;
                if (got !== eb) begin
                    n_fail++;
                    $display("FAIL %s beat %0d: got %h required %h", name, beats, got, eb);
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                beats++;
            end
            prev_stall = fft_if.FftInTvalid && !fft_if.FftInTready;
            prev_beat  = got;
            if (SymValid) begin
                es = (sym_q.size() > 0) ? sym_q.pop_front() : 2'bxx;
                n_checks++;
                if ({SymData, SymLast} !== {es, (syms == 4095)}) begin
                    n_fail++;
                    $display("FAIL %s sym %0d: got %b/%b required %b/%b", name, syms,
                             SymData, SymLast, es, (syms == 4095));
                end
                syms++;
            end
            if (FrameDone) begin
                dones++;
                n_checks++;
                if ({Busy, prev_symlast, 13'(syms)} !== {2'b01, 13'd4096}) begin
                    n_fail++;
                    $display("FAIL %s frame_done: got busy=%b prev_symlast=%b syms=%0d required 0/1/4096",
                             name, Busy, prev_symlast, syms);
                end
            end
            prev_symlast = SymLast;
        end
        n_checks++;
        if (dones != 1 || beats != 4096 || beat_q.size() != 0 || sym_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s totals: got done=%0d beats=%0d left=%0d/%0d required 1/4096/0/0",
                     name, dones, beats, beat_q.size(), sym_q.size());
        end
        beat_q.delete();
        sym_q.delete();
    endtask

    task automatic test_reset();
        Srst = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (out_vec() !== 51'd1) begin
            n_fail++;
            $display("FAIL reset_values: got %h required %h", out_vec(), 51'd1);
        end
        #1 Srst = 1'b0;
        junk_valid = 1'b1;
        repeat (3) begin
            @(negedge Clk);
            n_checks++;
            if (SymValid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_fft_out_ignored: got %b required 0", SymValid);
            end
        end
        junk_valid = 1'b0;
    endtask

    task automatic test_corner_turn();
        int f, l;
        pulse_start();
        cfg_handshake(0);
        capture_frame(0);
        check_stream("corner_turn", 1'b0, f, l);
        n_checks++;
        if (l - f !== 4095) begin
            n_fail++;
            $display("FAIL contiguous_feed: got span %0d required 4095", l - f);
        end
    endtask

    task automatic test_backpressure();
        int f, l;
        bp_en = 1'b1;
        pulse_start();
        cfg_handshake(0);
        capture_frame(2);
        check_stream("backpressure", 1'b0, f, l);
        bp_en = 1'b0;
    endtask

    task automatic test_config_stall();
        int f, l;
        pulse_start();
        cfg_handshake(10);
        n_checks++;
        if (RxOverrun !== 1'b1) begin
            n_fail++;
            $display("FAIL config_overrun: got %b required 1", RxOverrun);
        end
        capture_frame(3);
        check_stream("config_stall", 1'b0, f, l);
    endtask

    task automatic test_overrun();
        int f, l;
        pulse_start();
        cfg_handshake(0);
        capture_frame(2);
        check_stream("overrun", 1'b1, f, l);
        repeat (5) begin
            @(negedge Clk);
            n_checks++;
            if (RxOverrun !== 1'b1) begin
                n_fail++;
                $display("FAIL overrun_sticky: got %b required 1", RxOverrun);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int f, l;
        pulse_start();
        cfg_handshake(0);
        for (int t = 0; t < 2000; t++) begin
            #1 RxDataValid = 1'b1;
            cfg_ready = 1'b0;
            RxDataRe  = 16'($urandom);
            RxDataIm  = 16'($urandom);
            @(posedge Clk);
        end
        #1 RxDataValid = 1'b0;
        Srst = 1'b1;
        @(posedge Clk); #1 Srst = 1'b0;
        n_checks++;
        if (out_vec() !== 51'd1) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h required %h", out_vec(), 51'd1);
        end
        pulse_start();
        cfg_handshake(0);
        capture_frame(3);
        check_stream("after_reset", 1'b0, f, l);
    endtask

    task automatic test_demap_boundaries();
        int f, l;
        pulse_start();
        cfg_handshake(0);
        capture_frame(1);
        check_stream("demap_boundaries", 1'b0, f, l);
    endtask

    // Entered on the FrameDone cycle left by the previous frame.
    task automatic test_back_to_back();
        int f, l;
        Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
        n_checks++;
        if ({Busy, fft_if.CfgTvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_on_done_ignored: got %b required 00", {Busy, fft_if.CfgTvalid});
        end
        Start = 1'b1;
        @(posedge Clk); #1 Start = 1'b0;
        n_checks++;
        if ({Busy, fft_if.CfgTvalid} !== 2'b11) begin
            n_fail++;
            $display("FAIL start_after_done: got %b required 11", {Busy, fft_if.CfgTvalid});
        end
        cfg_handshake(0);
        capture_frame(2);
        check_stream("back_to_back", 1'b0, f, l);
    endtask

    initial begin
        test_reset();
        test_corner_turn();
        test_backpressure();
        test_config_stall();
        test_overrun();
        test_reset_midframe();
        test_demap_boundaries();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
